// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the instruction fetch front end: buffer entry layout,
// sequencer state encoding and the default reset vector.
package fetch_sequencer_pkg;

   localparam logic [0:31] RESET_VECTOR = 32'h0000_0100;

   typedef struct packed {
      logic [0:31] cia;
      logic [0:31] instr;
   } fetch_entry_t;

   typedef enum logic {
      RUN,
      DRAIN
   } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer (master side) and its neighbours:
// branch-unit redirect, instruction memory request/response and decode.
interface fetch_sequencer_if;

   logic        nia_valid;
   logic [0:31] nia_out;
   logic        fetch_req_valid;
   logic        fetch_req_ready;
   logic [0:31] fetch_addr;
   logic        fetch_rsp_valid;
   logic [0:31] fetch_rsp_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [0:31] instr_out;
   logic [0:31] cia_out;

   modport master (
      input  nia_valid, nia_out,
      input  fetch_req_ready, fetch_rsp_valid, fetch_rsp_data,
      input  instr_ready,
      output fetch_req_valid, fetch_addr,
      output instr_valid, instr_out, cia_out
   );

   modport slave (
      output nia_valid, nia_out,
      output fetch_req_ready, fetch_rsp_valid, fetch_rsp_data,
      output instr_ready,
      input  fetch_req_valid, fetch_addr,
      input  instr_valid, instr_out, cia_out
   );

endinterface

// File: rtl/fetch_sequencer_fifo.sv
// Synchronous FIFO with push, pop, synchronous flush and occupancy count.
// Flush wins over a same-cycle push; the head entry is always visible on rd_data.
module fetch_sequencer_fifo #(
   parameter int  DEPTH = 4,
   parameter int  CW    = $clog2(DEPTH + 1),
   parameter type T     = logic [0:31]
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  T              wr_data,
   output T              rd_data,
   output logic [CW-1:0] count
);

   localparam int            AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   T              mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   // NOTE: storage is deliberately not reset; pointers and count alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= wr_data;
   end

   // NOTE: all sequential state uses non-blocking assignment so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= bump(wr_ptr);
         if (pop)  rd_ptr <= bump(rd_ptr);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign rd_data = mem[rd_ptr];

   overflow_a:  assert property (@(posedge clk) disable iff (rst)
                                 !(push && !pop && !flush && count == CW'(DEPTH)));
   underflow_a: assert property (@(posedge clk) disable iff (rst)
                                 !(pop && !flush && count == '0));

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch front end: owns the PC, issues in-order word fetches, tags returned
// words with their address for decode, and discards wrong-path fetches on redirect.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter logic [0:31] RESET_ADDR      = RESET_VECTOR,
   parameter int          FIFO_DEPTH      = 4,
   parameter int          MAX_OUTSTANDING = 4
) (
   input logic               clk,
   input logic               rst,
   fetch_sequencer_if.master fs
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int OCC_W = CNT_W + 1;

   fetch_state_t     state;
   logic [0:31]      pc;
   logic [CNT_W-1:0] outstanding;
   logic [CNT_W-1:0] outstanding_next;
   logic [CNT_W-1:0] discard_cnt;
   logic [CNT_W-1:0] instr_count;
   logic [CNT_W-1:0] tag_count;
   logic [OCC_W-1:0] occupancy;
   logic [0:31]      redirect_pc;
   logic [0:31]      tag_head;
   logic             req_valid;
   logic             req_fire;
   logic             rsp_run;
   logic             redirect_run;
   logic             instr_pop;
   fetch_entry_t     rsp_entry;
   fetch_entry_t     head_entry;

   // Every issued request reserves a buffer slot, so a response can never find the buffer full.
   assign occupancy = {1'b0, instr_count} + {1'b0, outstanding};
   assign req_valid = !rst && (state == RUN) && !fs.nia_valid
                      && (outstanding < CNT_W'(MAX_OUTSTANDING))
                      && (occupancy < OCC_W'(FIFO_DEPTH));

   assign req_fire         = req_valid && fs.fetch_req_ready;
   assign rsp_run          = fs.fetch_rsp_valid && (state == RUN);
   assign redirect_run     = fs.nia_valid && (state == RUN);
   assign instr_pop        = fs.instr_valid && fs.instr_ready;
   assign redirect_pc      = fs.nia_out & 32'hFFFF_FFFC;
   assign outstanding_next = outstanding + CNT_W'(req_fire) - CNT_W'(fs.fetch_rsp_valid);
   assign rsp_entry        = '{cia: tag_head, instr: fs.fetch_rsp_data};

   assign fs.fetch_req_valid = req_valid;
   assign fs.fetch_addr      = pc;
   assign fs.instr_valid     = (instr_count != '0);
   assign fs.instr_out       = head_entry.instr;
   assign fs.cia_out         = head_entry.cia;

   fetch_sequencer_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CW    (CNT_W),
      .T     (fetch_entry_t)
   ) u_instr_buf (
      .clk     (clk),
      .rst     (rst),
      .push    (rsp_run),
      .pop     (instr_pop),
      .flush   (redirect_run),
      .wr_data (rsp_entry),
      .rd_data (head_entry),
      .count   (instr_count)
   );

   fetch_sequencer_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .CW    (CNT_W),
      .T     (logic [0:31])
   ) u_tag_queue (
      .clk     (clk),
      .rst     (rst),
      .push    (req_fire),
      .pop     (rsp_run),
      .flush   (redirect_run),
      .wr_data (pc),
      .rd_data (tag_head),
      .count   (tag_count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         pc          <= RESET_ADDR;
         outstanding <= '0;
         discard_cnt <= '0;
      end else begin
         outstanding <= outstanding_next;
         if (req_fire) pc <= pc + 32'd4;
         unique case (state)
            RUN: begin
               // Requests still in flight at a redirect, net of any response now arriving, are wrong-path.
               if (fs.nia_valid) begin
                  pc          <= redirect_pc;
                  discard_cnt <= outstanding_next;
                  if (outstanding_next != '0) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (fs.nia_valid) pc <= redirect_pc;
               if (fs.fetch_rsp_valid) begin
                  discard_cnt <= discard_cnt - 1'b1;
                  if (discard_cnt == CNT_W'(1)) state <= RUN;
               end
            end
         endcase
      end
   end

   tag_track_a: assert property (@(posedge clk) disable iff (rst)
                                 (state == RUN) |-> (tag_count == outstanding));

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a vector table for streaming and decode
// stall, plus hand-written redirect, wrap and reset sequences.
module tb_fetch_sequencer;

   logic clk;
   logic rst;

   fetch_sequencer_if fs();

   fetch_sequencer #(
      .RESET_ADDR      (32'h0000_0100),
      .FIFO_DEPTH      (4),
      .MAX_OUTSTANDING (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .fs  (fs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] cia;
      logic [31:0] instr;
   } obs_t;

   typedef struct {
      logic        instr_ready;
      logic        exp_req_valid;
      logic [31:0] exp_addr;
      logic        exp_instr_valid;
      logic [31:0] exp_cia;
   } vec_t;

   int          checks   = 0;
   int          failures = 0;
   logic        mem_rsp_en;
   logic [31:0] mem_q   [$];
   logic [31:0] req_log [$];
   obs_t        got_q   [$];
   logic        s_req_valid;
   logic        s_instr_valid;
   logic [31:0] s_addr;
   logic [31:0] s_cia;
   logic [31:0] s_instr;
   vec_t        vecs [16];

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return a ^ 32'h5A5A_5A5A;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock: memory drives its oldest pending word, outputs are sampled, then the edge.
   task automatic cycle();
      logic rsp_fire;
      logic req_fire;
      logic dec_fire;
      if (mem_rsp_en && mem_q.size() > 0) begin
         fs.fetch_rsp_valid = 1'b1;
         fs.fetch_rsp_data  = word_of(mem_q[0]);
      end else begin
         fs.fetch_rsp_valid = 1'b0;
         fs.fetch_rsp_data  = '0;
      end
      #1;
      s_req_valid   = fs.fetch_req_valid;
      s_addr        = fs.fetch_addr;
      s_instr_valid = fs.instr_valid;
      s_cia         = fs.cia_out;
      s_instr       = fs.instr_out;
      rsp_fire      = fs.fetch_rsp_valid;
      req_fire      = fs.fetch_req_valid && fs.fetch_req_ready;
      dec_fire      = fs.instr_valid && fs.instr_ready;
      @(posedge clk);
      if (rst) begin
         mem_q.delete();
      end else begin
         if (rsp_fire) void'(mem_q.pop_front());
         if (req_fire) begin
            mem_q.push_back(s_addr);
            req_log.push_back(s_addr);
         end
         if (dec_fire) got_q.push_back('{cia: s_cia, instr: s_instr});
      end
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic redirect(input logic [31:0] target);
      fs.nia_valid = 1'b1;
      fs.nia_out   = target;
      cycle();
      fs.nia_valid = 1'b0;
   endtask

   task automatic do_reset();
      fs.nia_valid       = 1'b0;
      fs.fetch_req_ready = 1'b1;
      fs.instr_ready     = 1'b1;
      mem_rsp_en         = 1'b1;
      rst                = 1'b1;
      run(2);
      rst = 1'b0;
      got_q.delete();
      req_log.delete();
   endtask

   task automatic check_got(input string name, input int idx, input logic [31:0] exp_cia);
      obs_t o;
      o = (got_q.size() > idx) ? got_q[idx] : '{cia: 32'hDEAD_DEAD, instr: 32'hDEAD_DEAD};
      check({name, " cia"}, o.cia, exp_cia);
      check({name, " instr"}, o.instr, word_of(exp_cia));
   endtask

   initial begin
      fs.nia_valid       = 1'b0;
      fs.nia_out         = '0;
      fs.fetch_req_ready = 1'b1;
      fs.fetch_rsp_valid = 1'b0;
      fs.fetch_rsp_data  = '0;
      fs.instr_ready     = 1'b1;
      mem_rsp_en         = 1'b1;
      rst                = 1'b1;

      // {instr_ready, exp_req_valid, exp_addr, exp_instr_valid, exp_cia}
      vecs[0]  = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h000};
      vecs[1]  = '{1'b1, 1'b1, 32'h104, 1'b0, 32'h000};
      vecs[2]  = '{1'b1, 1'b1, 32'h108, 1'b1, 32'h100};
      vecs[3]  = '{1'b1, 1'b1, 32'h10C, 1'b1, 32'h104};
      vecs[4]  = '{1'b1, 1'b1, 32'h110, 1'b1, 32'h108};
      vecs[5]  = '{1'b1, 1'b1, 32'h114, 1'b1, 32'h10C};
      vecs[6]  = '{1'b1, 1'b1, 32'h118, 1'b1, 32'h110};
      vecs[7]  = '{1'b1, 1'b1, 32'h11C, 1'b1, 32'h114};
      vecs[8]  = '{1'b0, 1'b1, 32'h120, 1'b1, 32'h118};
      vecs[9]  = '{1'b0, 1'b1, 32'h124, 1'b1, 32'h118};
      vecs[10] = '{1'b0, 1'b0, 32'h128, 1'b1, 32'h118};
      vecs[11] = '{1'b1, 1'b0, 32'h128, 1'b1, 32'h118};
      vecs[12] = '{1'b1, 1'b1, 32'h128, 1'b1, 32'h11C};
      vecs[13] = '{1'b1, 1'b1, 32'h12C, 1'b1, 32'h120};
      vecs[14] = '{1'b1, 1'b1, 32'h130, 1'b1, 32'h124};
      vecs[15] = '{1'b1, 1'b1, 32'h134, 1'b1, 32'h128};

      // Reset values, sampled while rst is still held.
      do_reset();
      check("reset req_valid", 32'(s_req_valid), 32'h0);
      check("reset instr_valid", 32'(s_instr_valid), 32'h0);
      check("reset fetch_addr", s_addr, 32'h100);

      // Streaming, then a short decode stall and release.
      for (int i = 0; i < 16; i++) begin
         fs.instr_ready = vecs[i].instr_ready;
         cycle();
         check($sformatf("vec%0d req_valid", i), 32'(s_req_valid), 32'(vecs[i].exp_req_valid));
         check($sformatf("vec%0d fetch_addr", i), s_addr, vecs[i].exp_addr);
         check($sformatf("vec%0d instr_valid", i), 32'(s_instr_valid), 32'(vecs[i].exp_instr_valid));
         if (vecs[i].exp_instr_valid) begin
            check($sformatf("vec%0d cia", i), s_cia, vecs[i].exp_cia);
            check($sformatf("vec%0d instr", i), s_instr, word_of(vecs[i].exp_cia));
         end
      end

      // Decode stalled from reset: buffer plus in-flight caps issue at four.
      do_reset();
      fs.instr_ready = 1'b0;
      run(8);
      check("stall request count", 32'(req_log.size()), 32'd4);
      check("stall req_valid", 32'(s_req_valid), 32'h0);
      fs.instr_ready = 1'b1;
      run(12);
      for (int i = 0; i < 10; i++) check_got($sformatf("stall got%0d", i), i, 32'h100 + 32'(4 * i));

      // Three outstanding, redirect to 0x2003: all three are discarded.
      do_reset();
      mem_rsp_en = 1'b0;
      run(3);
      redirect(32'h0000_2003);
      check("redir3 req_valid", 32'(s_req_valid), 32'h0);
      mem_rsp_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check($sformatf("drain%0d req_valid", i), 32'(s_req_valid), 32'h0);
         check($sformatf("drain%0d instr_valid", i), 32'(s_instr_valid), 32'h0);
      end
      cycle();
      check("redir3 resume req_valid", 32'(s_req_valid), 32'h1);
      check("redir3 resume addr", s_addr, 32'h2000);
      run(4);
      check_got("redir3 first", 0, 32'h2000);

      // Redirect together with a response and a ready memory: the response is dropped.
      do_reset();
      mem_rsp_en = 1'b0;
      run(2);
      mem_rsp_en = 1'b1;
      redirect(32'h0000_3000);
      check("redir_rsp req_valid", 32'(s_req_valid), 32'h0);
      cycle();
      check("redir_rsp drain req_valid", 32'(s_req_valid), 32'h0);
      check("redir_rsp drain instr_valid", 32'(s_instr_valid), 32'h0);
      cycle();
      check("redir_rsp resume req_valid", 32'(s_req_valid), 32'h1);
      check("redir_rsp resume addr", s_addr, 32'h3000);
      run(4);
      check_got("redir_rsp first", 0, 32'h3000);

      // Redirect during a decode handshake: it completes, then instr_valid drops.
      do_reset();
      run(4);
      redirect(32'h0000_4000);
      check("redir_dec instr_valid", 32'(s_instr_valid), 32'h1);
      check("redir_dec got count", 32'(got_q.size()), 32'd3);
      check_got("redir_dec last", 2, 32'h108);
      cycle();
      check("redir_dec next instr_valid", 32'(s_instr_valid), 32'h0);
      check("redir_dec next req_valid", 32'(s_req_valid), 32'h1);
      check("redir_dec next addr", s_addr, 32'h4000);
      run(5);
      check_got("redir_dec new", 3, 32'h4000);

      // PC wrap, with a request held while memory is not ready.
      do_reset();
      redirect(32'hFFFF_FFF8);
      fs.fetch_req_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cycle();
         check($sformatf("hold%0d req_valid", i), 32'(s_req_valid), 32'h1);
         check($sformatf("hold%0d addr", i), s_addr, 32'hFFFF_FFF8);
      end
      fs.fetch_req_ready = 1'b1;
      run(6);
      check("wrap req0", (req_log.size() > 0) ? req_log[0] : 32'hDEAD_DEAD, 32'hFFFF_FFF8);
      check("wrap req1", (req_log.size() > 1) ? req_log[1] : 32'hDEAD_DEAD, 32'hFFFF_FFFC);
      check("wrap req2", (req_log.size() > 2) ? req_log[2] : 32'hDEAD_DEAD, 32'h0000_0000);
      check_got("wrap got2", 2, 32'h0000_0000);

      // Reset while draining with two outstanding.
      do_reset();
      mem_rsp_en = 1'b0;
      run(2);
      redirect(32'h0000_5000);
      rst = 1'b1;
      cycle();
      cycle();
      check("rst_drain instr_valid", 32'(s_instr_valid), 32'h0);
      check("rst_drain req_valid", 32'(s_req_valid), 32'h0);
      rst = 1'b0;
      got_q.delete();
      mem_rsp_en = 1'b1;
      cycle();
      check("rst_drain restart req_valid", 32'(s_req_valid), 32'h1);
      check("rst_drain restart addr", s_addr, 32'h100);
      run(4);
      check_got("rst_drain first", 0, 32'h100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1);
   end

endmodule
